mont_to_norm_3329: RTL and testbench

Streaming Montgomery-domain exit stage for the q = 3329, R = 2^12 arithmetic datapath. It accepts 12-bit coefficients in Montgomery form, x·R mod q, and returns the normal-domain value x mod q, computed as REDC(x) = x·R⁻¹ mod q. It is the decoding counterpart of the front-end multiplier, which lifts operands into Montgomery form by multiplying with R² mod q = 2385. Transfers on both sides use valid/ready handshakes, and the datapath is a fixed 3-stage pipeline.

---
 rtl/mont_to_norm_3329.sv | 114 +++++++++++
 tb/tb_mont_to_norm_3329.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mont_to_norm_3329.sv
// Montgomery-domain exit stage for q = 3329, R = 2^12: 3-stage REDC pipeline with valid/ready handshakes.
// Optional per-beat range flag enabled by defining M2N_RANGE_CHK_EN.
module mont_to_norm_3329 #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MOD     = 3329,
    parameter int unsigned MOD_INV = 3327
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam logic [11:0] MOD_C     = 12'(MOD);
    localparam logic [11:0] MOD_INV_C = 12'(MOD_INV);

    logic             adv;
    logic             v1, v2, v3;
    logic [11:0]      x1, x2, m2, data3;
    logic [TAG_W-1:0] tag1, tag2, tag3;

    logic [11:0]      m_next;
    logic [24:0]      sum;
    logic [12:0]      t;
    logic [11:0]      red;

    // Whole pipeline moves as one; only a stalled S3 beat can hold it.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign out_data  = data3;
    assign out_tag   = tag3;
    assign busy      = v1 || v2 || v3;

    always_comb begin
        m_next = x1 * MOD_INV_C;
        sum    = {13'd0, x2} + ({13'd0, m2} * {13'd0, MOD_C});
        t      = 13'(sum >> 12);
        red    = (t >= {1'b0, MOD_C}) ? 12'(t - {1'b0, MOD_C}) : t[11:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1   <= '0;
            tag1 <= '0;
        end else if (adv && in_valid) begin
            x1   <= in_data;
            tag1 <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x2   <= '0;
            m2   <= '0;
            tag2 <= '0;
        end else if (adv && v1) begin
            x2   <= x1;
            m2   <= m_next;
            tag2 <= tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data3 <= '0;
            tag3  <= '0;
        end else if (adv && v2) begin
            data3 <= red;
            tag3  <= tag2;
        end
    end

`ifdef M2N_RANGE_CHK_EN
    logic err1, err2, err3;

    always_ff @(posedge clk) begin
        if (rst) begin
            err1 <= 1'b0;
            err2 <= 1'b0;
            err3 <= 1'b0;
        end else if (adv) begin
            if (in_valid) err1 <= (in_data >= MOD_C);
            if (v1)       err2 <= err1;
            if (v2)       err3 <= err2;
        end
    end

    assign out_err = err3;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mont_to_norm_3329.sv
// Self-checking bench for mont_to_norm_3329: scoreboard queue filled on accept, drained on output transfer.
module tb_mont_to_norm_3329;

    localparam int unsigned TAG_W = 4;
`ifdef M2N_RANGE_CHK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [11:0]      in_data   = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [11:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int ph       = 0;
    bit mon_en   = 1'b0;
    bit lat_chk  = 1'b0;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  t;
        logic        e;
        int          c;
    } exp_t;
    exp_t sb[$];

    mont_to_norm_3329 #(.TAG_W(TAG_W), .MOD(3329), .MOD_INV(3327)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    function automatic logic [11:0] model(input int x);
        return 12'((x * 2704) % 3329);
    endfunction

    function automatic logic model_err(input int x);
        return RANGE_EN && (x >= 3329);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int x, input logic [11:0] ed, input logic ee);
        bit acc = 1'b0;
        int c   = 0;
        in_valid = 1'b1;
        in_data  = 12'(x);
        in_tag   = 4'(x);
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            c   = cyc;
            @(posedge clk);
            #1;
            if (acc) sb.push_back('{ed, 4'(x), ee, c});
        end
        in_valid = 1'b0;
        check("send_accept", int'(acc), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: handshake rule, busy vs in-flight count, stall stability, scoreboard compare.
    bit   was_stall = 1'b0;
    int   hold      = 0;
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            check("busy", int'(busy), int'(sb.size() != 0));
            if (rst) begin
                sb.delete();
                was_stall = 1'b0;
            end else begin
                if (was_stall)
                    check("stall_hold", int'({out_valid, out_data, out_tag, out_err}), hold);
                if (out_valid) begin
                    check("out_pending", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb[0];
                        check("out_data", int'(out_data), int'(e.d));
                        check("out_tag", int'(out_tag), int'(e.t));
                        check("out_err", int'(out_err), int'(e.e));
                        if (out_ready) begin
                            if (lat_chk) check("latency", cyc - e.c, 3);
                            void'(sb.pop_front());
                        end
                    end
                end
                was_stall = out_valid && !out_ready;
                hold      = int'({out_valid, out_data, out_tag, out_err});
            end
        end
    end

    int kin [5] = '{0, 767, 1534, 2385, 1};
    int kexp[5] = '{0, 1, 2, 767, 2704};
    int rin [3] = '{3328, 3329, 4095};

    initial begin
        // Reset with a beat presented: it must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'd123;
        in_tag   = 4'd5;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_out_data", int'(out_data), 0);
            check("rst_out_tag", int'(out_tag), 0);
            check("rst_out_err", int'(out_err), 0);
        end
        @(posedge clk);
        #1;

        // Known vectors, back-to-back, fixed latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(kin[i], 12'(kexp[i]), 1'b0);
        drain();
        lat_chk = 1'b0;

        // Reset mid-stream: three beats in flight are discarded.
        for (int i = 0; i < 3; i++) send(100 + i, model(100 + i), model_err(100 + i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 1);
        repeat (5) begin
            @(negedge clk);
            check("mid_rst_out_valid", int'(out_valid), 0);
            check("mid_rst_busy", int'(busy), 0);
            check("mid_rst_out_data", int'(out_data), 0);
        end
        @(posedge clk);
        #1;

        // Backpressure: 1-on / 2-off out_ready.
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) send(200 * i + 7, model(200 * i + 7), model_err(200 * i + 7));
        drain();
        rdy_mode = 0;

        // Range boundary.
        for (int i = 0; i < 3; i++) send(rin[i], model(rin[i]), model_err(rin[i]));
        drain();

        // Exhaustive with random gaps and random out_ready.
        rdy_mode = 2;
        for (int x = 0; x < 4096; x++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            send(x, model(x), model_err(x));
        end
        drain();
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
